// File: rtl/core_debug_responder.sv
// Debug register slave: exposes run control, PC/instruction snoop, a retired-instruction
// counter and step/jump requests to the core over a simple held-enable bus.
// Latency: register accesses complete one cycle after acceptance; step/jump wait for
// coreAck (up to ACK_TIMEOUT cycles). Backpressure: wbBusy stays high until done, and
// the slave needs one cycle with wbEnable low between transactions.
//
// Ports:
//   clk, rst             - system clock, synchronous active-high reset
//   wbEnable .. wbBusy   - bus side: enable held for the transaction, write flag,
//                          byte address (bits [1:0] ignored), byte lanes, data, busy
//   coreRun              - core may execute (mirrors CONFIG.run)
//   coreStep/coreJump    - level requests held until coreAck or timeout
//   coreJumpAddress      - jump target, valid while coreJump is high
//   coreAck              - core accepted the step/jump
//   corePC, coreInstruction - live core state, readable through the map
//   coreRetire           - one pulse per retired instruction
module core_debug_responder #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbEnable,
  input  logic        wbWriteEnable,
  input  logic [23:0] wbAddress,
  input  logic [3:0]  wbByteSelect,
  input  logic [31:0] wbDataWrite,
  output logic [31:0] wbDataRead,
  output logic        wbBusy,
  output logic        coreRun,
  output logic        coreStep,
  output logic        coreJump,
  output logic [31:0] coreJumpAddress,
  input  logic        coreAck,
  input  logic [31:0] corePC,
  input  logic [31:0] coreInstruction,
  input  logic        coreRetire
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CORE = 2'd1,
    DONE      = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          run_q, run_d;
  logic          err_q, err_d;
  logic [31:0]   retired_q, retired_d;
  logic          step_q, step_d;
  logic          jump_q, jump_d;
  logic [31:0]   jaddr_q, jaddr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          err_set, err_clr, ret_clr;

  // Address decode: only word offsets 0x00..0x14 with all upper bits zero are mapped.
  logic [2:0]    reg_idx;
  logic          in_map;
  logic          sel_config, sel_jump, sel_step, sel_retired;
  logic          wr_any;
  logic          ctrl_wr;
  logic [31:0]   rd_mux;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^wbAddress[1:0];

  assign reg_idx     = wbAddress[4:2];
  assign in_map      = (wbAddress[23:5] == '0) && (reg_idx <= 3'd5);
  assign sel_config  = in_map && (reg_idx == 3'd0);
  assign sel_jump    = in_map && (reg_idx == 3'd2);
  assign sel_step    = in_map && (reg_idx == 3'd3);
  assign sel_retired = in_map && (reg_idx == 3'd5);
  assign wr_any      = wbWriteEnable && (wbByteSelect != 4'd0);
  assign ctrl_wr     = wr_any && (sel_jump || sel_step);

  always_comb begin
    rd_mux = 32'd0;
    if (in_map) begin
      case (reg_idx)
        3'd0:    rd_mux = {30'd0, err_q, run_q};
        3'd1:    rd_mux = corePC;
        3'd4:    rd_mux = coreInstruction;
        3'd5:    rd_mux = retired_q;
        default: rd_mux = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    step_d  = step_q;
    jump_d  = jump_q;
    jaddr_d = jaddr_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    err_clr = 1'b0;
    ret_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (wbEnable) begin
          rdata_d = rd_mux;
          if (ctrl_wr && !run_q) begin
            state_d = WAIT_CORE;
            step_d  = sel_step;
            jump_d  = sel_jump;
            if (sel_jump) jaddr_d = wbDataWrite;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            // Stepping or jumping a running core is refused and flagged.
            if (ctrl_wr) err_set = 1'b1;
            if (wbWriteEnable && sel_config && wbByteSelect[0]) begin
              run_d   = wbDataWrite[0];
              err_clr = wbDataWrite[1];
            end
            if (wr_any && sel_retired) ret_clr = 1'b1;
          end
        end
      end

      WAIT_CORE: begin
        if (coreAck) begin
          state_d = DONE;
          step_d  = 1'b0;
          jump_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          // Request has been visible for ACK_TIMEOUT cycles without an ack.
          state_d = DONE;
          step_d  = 1'b0;
          jump_d  = 1'b0;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      DONE: begin
        if (!wbEnable) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // A new error wins over a simultaneous write-1-to-clear.
  assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

  // A clearing write wins over a simultaneous retire.
  assign retired_d = ret_clr ? 32'd0 :
                     (coreRetire && run_q) ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= 32'd0;
      step_q    <= 1'b0;
      jump_q    <= 1'b0;
      jaddr_q   <= 32'd0;
      rdata_q   <= 32'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      step_q    <= step_d;
      jump_q    <= jump_d;
      jaddr_q   <= jaddr_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wbBusy          = wbEnable && (state_q != DONE);
  assign wbDataRead      = rdata_q;
  assign coreRun         = run_q;
  assign coreStep        = step_q;
  assign coreJump        = jump_q;
  assign coreJumpAddress = jaddr_q;

endmodule

// File: tb/tb_core_debug_responder.sv
// Bench for core_debug_responder: directed scenarios plus randomized bus traffic,
// compared against a register-level model of the debug map.
// Inputs are driven 1ns after the rising edge and outputs sampled on the falling edge.
module tb_core_debug_responder;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbEnable, wbWriteEnable;
  logic [23:0] wbAddress;
  logic [3:0]  wbByteSelect;
  logic [31:0] wbDataWrite, wbDataRead;
  logic        wbBusy, coreRun, coreStep, coreJump;
  logic [31:0] coreJumpAddress;
  logic        coreAck;
  logic [31:0] corePC, coreInstruction;
  logic        coreRetire;

  core_debug_responder #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .wbEnable(wbEnable), .wbWriteEnable(wbWriteEnable), .wbAddress(wbAddress),
    .wbByteSelect(wbByteSelect), .wbDataWrite(wbDataWrite), .wbDataRead(wbDataRead),
    .wbBusy(wbBusy), .coreRun(coreRun), .coreStep(coreStep), .coreJump(coreJump),
    .coreJumpAddress(coreJumpAddress), .coreAck(coreAck), .corePC(corePC),
    .coreInstruction(coreInstruction), .coreRetire(coreRetire)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of architectural state.
  logic        m_run, m_err;
  logic [31:0] m_retired;

  logic [31:0] rd;
  int          bz, rq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_err = 1'b0; m_retired = 32'd0;
  endtask

  // Runs one bus transaction. coreAck rises in cycle N+ack_dly (0 = never);
  // coreRetire is pulsed in the acceptance cycle when retire0 is set.
  task automatic bus_xfer(input logic we, input logic [23:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int ack_dly, input logic retire0,
                          output logic [31:0] rdata, output int busy_n, output int req_n,
                          output logic [31:0] jaddr_seen);
    bit finished;
    @(posedge clk); #1;
    wbEnable = 1'b1; wbWriteEnable = we; wbAddress = addr;
    wbByteSelect = be; wbDataWrite = wdata;
    busy_n = 0; req_n = 0; jaddr_seen = 32'd0; finished = 1'b0;
    for (int k = 0; k < 64; k++) begin
      coreAck    = (ack_dly > 0) && (k >= ack_dly);
      coreRetire = (k == 0) ? retire0 : 1'b0;
      @(negedge clk);
      if (coreStep || coreJump) begin
        req_n++;
        if (coreJump) jaddr_seen = coreJumpAddress;
      end
      if (!wbBusy) begin
        finished = 1'b1;
        break;
      end
      busy_n++;
      @(posedge clk); #1;
    end
    if (!finished) $display("FAIL xfer_timeout got=busy exp=done addr=0x%06h", addr);
    rdata = wbDataRead;
    @(posedge clk); #1;
    wbEnable = 1'b0; wbWriteEnable = 1'b0; coreAck = 1'b0; coreRetire = 1'b0;
  endtask

  // One transaction checked against the model's view of the register map.
  task automatic do_op(input logic we, input logic [23:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input int ack_dly, input logic retire0,
                       output logic [31:0] rdata_o, output int busy_o, output int req_o);
    logic [31:0] exp_rd, jseen;
    logic [23:0] off;
    logic        mapped, is_ctrl, old_run, clears;
    int          exp_busy, exp_req;

    corePC          = $urandom;
    coreInstruction = $urandom;
    off     = {addr[23:2], 2'b00};
    mapped  = (off <= 24'h14);
    is_ctrl = we && (be != 4'd0) && mapped && (off == 24'h08 || off == 24'h0C);
    old_run = m_run;

    exp_rd = 32'd0;
    if (mapped) begin
      if (off == 24'h00) exp_rd = {30'd0, m_err, m_run};
      if (off == 24'h04) exp_rd = corePC;
      if (off == 24'h10) exp_rd = coreInstruction;
      if (off == 24'h14) exp_rd = m_retired;
    end

    exp_busy = 1; exp_req = 0; clears = 1'b0;
    if (is_ctrl && !m_run) begin
      if (ack_dly >= 1 && ack_dly <= TMO) begin
        exp_req = ack_dly; exp_busy = ack_dly + 1;
      end else begin
        exp_req = TMO; exp_busy = TMO + 1; m_err = 1'b1;
      end
    end else if (is_ctrl) begin
      m_err = 1'b1;
    end else if (we && mapped) begin
      if (off == 24'h00 && be[0]) begin
        m_run = wdata[0];
        if (wdata[1]) m_err = 1'b0;
      end
      if (off == 24'h14 && be != 4'd0) clears = 1'b1;
    end
    if (clears) m_retired = 32'd0;
    else if (retire0 && old_run) m_retired = m_retired + 32'd1;

    bus_xfer(we, addr, be, wdata, ack_dly, retire0, rdata_o, busy_o, req_o, jseen);

    check_eq("busy_cycles", busy_o, exp_busy);
    check_eq("req_cycles", req_o, exp_req);
    if (!we) check_eq("rdata", rdata_o, exp_rd);
    if (is_ctrl && off == 24'h08 && exp_req > 0) check_eq("jump_addr", jseen, wdata);
    @(negedge clk);
    check_eq("core_run", {31'd0, coreRun}, {31'd0, m_run});
    check_eq("req_idle", {30'd0, coreStep, coreJump}, 32'd0);
  endtask

  task automatic retire_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; coreRetire = 1'b1;
      @(posedge clk); #1; coreRetire = 1'b0;
      if (m_run) m_retired = m_retired + 32'd1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wbEnable = 1'b0; wbWriteEnable = 1'b0; wbAddress = '0;
    wbByteSelect = '0; wbDataWrite = '0; coreAck = 1'b0; corePC = '0;
    coreInstruction = '0; coreRetire = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_run",   {31'd0, coreRun}, 32'd0);
    check_eq("rst_step",  {31'd0, coreStep}, 32'd0);
    check_eq("rst_jump",  {31'd0, coreJump}, 32'd0);
    check_eq("rst_jaddr", coreJumpAddress, 32'd0);
    check_eq("rst_rdata", wbDataRead, 32'd0);
    check_eq("rst_busy",  {31'd0, wbBusy}, 32'd0);

    // CONFIG read after reset.
    do_op(1'b0, 24'h000000, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("cfg_after_rst", rd, 32'h0);
    check_eq("cfg_busy_1", bz, 32'd1);

    // STEP with ack three cycles later.
    do_op(1'b1, 24'h00000C, 4'hF, 32'd0, 3, 1'b0, rd, bz, rq);
    check_eq("step_req_3", rq, 32'd3);
    check_eq("step_busy_4", bz, 32'd4);
    do_op(1'b0, 24'h000000, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("step_no_err", rd, 32'h0);

    // JUMP never acked: timeout and sticky error.
    do_op(1'b1, 24'h000008, 4'hF, 32'h100, 0, 1'b0, rd, bz, rq);
    check_eq("jump_tmo_req", rq, 32'd15);
    do_op(1'b0, 24'h000000, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("jump_tmo_cfg", rd, 32'h2);
    do_op(1'b1, 24'h000000, 4'hF, 32'h2, 0, 1'b0, rd, bz, rq);

    // Retire counting only while running.
    do_op(1'b1, 24'h000000, 4'hF, 32'h1, 0, 1'b0, rd, bz, rq);
    retire_n(10);
    do_op(1'b1, 24'h000000, 4'hF, 32'h0, 0, 1'b0, rd, bz, rq);
    retire_n(5);
    do_op(1'b0, 24'h000014, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("retired_10", rd, 32'd10);

    // Counter wrap, then clear racing a retire.
    do_op(1'b1, 24'h000000, 4'hF, 32'h1, 0, 1'b0, rd, bz, rq);
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    do_op(1'b0, 24'h000014, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("retired_max", rd, 32'hFFFF_FFFF);
    retire_n(1);
    do_op(1'b0, 24'h000014, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("retired_wrap", rd, 32'd0);
    retire_n(3);
    do_op(1'b1, 24'h000014, 4'hF, 32'd0, 0, 1'b1, rd, bz, rq);
    do_op(1'b0, 24'h000014, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("clear_vs_retire", rd, 32'd0);

    // Reset while waiting for the core.
    do_op(1'b1, 24'h000000, 4'hF, 32'h2, 0, 1'b0, rd, bz, rq);
    @(posedge clk); #1;
    wbEnable = 1'b1; wbWriteEnable = 1'b1; wbAddress = 24'h00000C;
    wbByteSelect = 4'hF; wbDataWrite = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("wait_step_hi", {31'd0, coreStep}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; wbEnable = 1'b0; wbWriteEnable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_wait_step", {31'd0, coreStep}, 32'd0);
    check_eq("rst_wait_busy", {31'd0, wbBusy}, 32'd0);
    do_op(1'b0, 24'h000000, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("rst_wait_cfg", rd, 32'h0);
    do_op(1'b1, 24'h000000, 4'hF, 32'h1, 0, 1'b0, rd, bz, rq);
    do_op(1'b1, 24'h00000C, 4'hF, 32'd0, 2, 1'b0, rd, bz, rq);
    check_eq("run_step_noreq", rq, 32'd0);
    do_op(1'b0, 24'h000000, 4'hF, 32'd0, 0, 1'b0, rd, bz, rq);
    check_eq("run_step_cfg", rd, 32'h3);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  widx;
      logic [23:0] a;
      logic [3:0]  be;
      logic        we, r0;
      widx = 3'($urandom_range(0, 7));
      a    = {19'd0, widx, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a[23:5] = 19'($urandom_range(1, 524287));
      we = 1'($urandom_range(0, 1));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      r0 = 1'($urandom_range(0, 1));
      do_op(we, a, be, $urandom, $urandom_range(0, 18), r0, rd, bz, rq);
      retire_n($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
